// File: rtl/gemm_psum_accumulator_if.sv
// Handshake bundle between the MAC adder-tree stage, the partial-sum accumulator
// and the write-back consumer. The master drives beats in and consumes results.
interface gemm_psum_accumulator_if #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 16
);
    logic                        in_valid;
    logic                        in_ready;
    logic signed [IN_WIDTH-1:0]  in_data;
    logic                        in_first;
    logic                        in_last;
    logic [4:0]                  shift;
    logic                        out_valid;
    logic                        out_ready;
    logic signed [OUT_WIDTH-1:0] out_data;
    logic                        out_sat;
    logic                        acc_ovf;
    logic                        proto_err;

    modport master (
        output in_valid, in_data, in_first, in_last, shift, out_ready,
        input  in_ready, out_valid, out_data, out_sat, acc_ovf, proto_err
    );

    modport slave (
        input  in_valid, in_data, in_first, in_last, shift, out_ready,
        output in_ready, out_valid, out_data, out_sat, acc_ovf, proto_err
    );
endinterface

// File: rtl/gemm_psum_accumulator.sv
// Accumulates K-chunk partial sums per output element, rescales with a rounding
// arithmetic right shift, saturates, and queues results for write-back.
module gemm_psum_accumulator #(
    parameter int IN_WIDTH   = 32,
    parameter int ACC_WIDTH  = 40,
    parameter int OUT_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    gemm_psum_accumulator_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic signed [ACC_WIDTH:0] OMAX =
        {{(ACC_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] OMIN =
        {{(ACC_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic {IDLE, ACCUM} state_e;

    state_e                       state_q;
    logic signed [ACC_WIDTH-1:0]  acc_q;
    logic                         acc_ovf_q;
    logic                         proto_err_q;

    logic                         s1_vld_q;
    logic signed [ACC_WIDTH-1:0]  s1_sum_q;
    logic [4:0]                   s1_shift_q;

    logic [OUT_WIDTH-1:0]         mem_q [FIFO_DEPTH];
    logic                         mem_sat_q [FIFO_DEPTH];
    logic [PW-1:0]                wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]                cnt_q;
    logic [OUT_WIDTH-1:0]         last_data_q;
    logic                         last_sat_q;

    // ---------------------------------------------------------------- input side
    logic                         accept;
    logic                         restart;
    logic                         proto_viol;
    logic                         add_ovf;
    logic signed [IN_WIDTH-1:0]   in_s;
    logic signed [ACC_WIDTH-1:0]  in_ext;
    logic signed [ACC_WIDTH-1:0]  base;
    logic signed [ACC_WIDTH-1:0]  sum;

    // Pipeline occupancy counts as reserved FIFO space so an accepted beat always lands.
    assign bus.in_ready = ({1'b0, cnt_q} + (CW+1)'(s1_vld_q)) < (CW+1)'(FIFO_DEPTH);
    assign accept       = bus.in_valid & bus.in_ready;

    always_comb begin
        in_s       = bus.in_data;
        in_ext     = ACC_WIDTH'(in_s);
        restart    = (state_q == IDLE) | bus.in_first;
        base       = restart ? '0 : acc_q;
        sum        = base + in_ext;
        add_ovf    = (base[ACC_WIDTH-1] == in_ext[ACC_WIDTH-1]) &&
                     (sum[ACC_WIDTH-1] != base[ACC_WIDTH-1]);
        proto_viol = ((state_q == IDLE) & ~bus.in_first) |
                     ((state_q == ACCUM) & bus.in_first);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            acc_ovf_q   <= 1'b0;
            proto_err_q <= 1'b0;
            s1_vld_q    <= 1'b0;
            s1_sum_q    <= '0;
            s1_shift_q  <= '0;
        end else begin
            s1_vld_q <= accept & bus.in_last;
            if (accept) begin
                acc_q <= sum;
                if (add_ovf)    acc_ovf_q   <= 1'b1;
                if (proto_viol) proto_err_q <= 1'b1;
                if (bus.in_last) begin
                    state_q    <= IDLE;
                    s1_sum_q   <= sum;
                    s1_shift_q <= bus.shift;
                end else begin
                    state_q    <= ACCUM;
                end
            end
        end
    end

    // ---------------------------------------------------------------- rescale
    logic signed [ACC_WIDTH:0] f_ext;
    logic signed [ACC_WIDTH:0] rnd;
    logic signed [ACC_WIDTH:0] r;
    logic [OUT_WIDTH-1:0]      res_data;
    logic                      res_sat;

    // One extra bit keeps final + 2^(shift-1) from wrapping before the shift.
    always_comb begin
        f_ext = (ACC_WIDTH+1)'(s1_sum_q);
        rnd   = '0;
        if (s1_shift_q == 5'd0) begin
            r = f_ext;
        end else if (int'(s1_shift_q) >= ACC_WIDTH) begin
            r = {(ACC_WIDTH+1){f_ext[ACC_WIDTH]}};
        end else begin
            rnd = (ACC_WIDTH+1)'(1) << (s1_shift_q - 5'd1);
            r   = (f_ext + rnd) >>> s1_shift_q;
        end

        res_sat  = 1'b0;
        res_data = r[OUT_WIDTH-1:0];
        if (r > OMAX) begin
            res_sat  = 1'b1;
            res_data = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end else if (r < OMIN) begin
            res_sat  = 1'b1;
            res_data = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        end
    end

    // ---------------------------------------------------------------- output FIFO
    logic fifo_full;
    logic pop;
    logic push;

    assign fifo_full = (cnt_q == CW'(FIFO_DEPTH));
    assign pop       = bus.out_valid & bus.out_ready;
    assign push      = s1_vld_q & (~fifo_full | pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q]     <= res_data;
            mem_sat_q[wr_ptr_q] <= res_sat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            last_data_q <= '0;
            last_sat_q  <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop) begin
                rd_ptr_q    <= rd_ptr_q + PW'(1);
                last_data_q <= mem_q[rd_ptr_q];
                last_sat_q  <= mem_sat_q[rd_ptr_q];
            end
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
        end
    end

    // When empty, present the most recently delivered entry rather than stale storage.
    assign bus.out_valid = (cnt_q != '0);
    assign bus.out_data  = bus.out_valid ? mem_q[rd_ptr_q] : last_data_q;
    assign bus.out_sat   = bus.out_valid ? mem_sat_q[rd_ptr_q] : last_sat_q;
    assign bus.acc_ovf   = acc_ovf_q;
    assign bus.proto_err = proto_err_q;

endmodule
